// File: rtl/signed_sat_accumulator.sv
// Folds a stream of signed samples into a per-frame saturating sum and presents
// one result per frame on a valid/ready output.
module signed_sat_accumulator #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_LEN);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [WIDTH-1:0] sum_raw;
  logic             ovf;
  logic [WIDTH-1:0] sum_sat;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;

  // Saturating add of the incoming sample onto the running sum.
  always_comb begin
    sum_raw = acc_q + in_data;
    ovf     = (acc_q[WIDTH-1] == in_data[WIDTH-1]) && (sum_raw[WIDTH-1] != acc_q[WIDTH-1]);
    sum_sat = sum_raw;
    if (ovf) begin
      sum_sat = acc_q[WIDTH-1] ? MinNeg : MaxPos;
    end
  end

  // Handshake outputs depend on state only, so no combinational ready/valid paths.
  always_comb begin
    in_ready  = (state_q == StAcc);
    out_valid = (state_q == StOut);
    out_sum   = acc_q;
    out_sat   = sat_q;
    out_count = cnt_q;
    beat      = in_valid && in_ready;
    cnt_inc   = cnt_q + CNT_W'(1);
  end

  // Next-state: accumulate on beats, close on in_last or full count, clear on drain.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      StAcc: begin
        if (beat) begin
          acc_d = sum_sat;
          cnt_d = cnt_inc;
          sat_d = sat_q | ovf;
          if (in_last || (cnt_inc == MaxCnt)) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  // State and datapath registers; reset discards any in-flight frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench for signed_sat_accumulator (WIDTH=4, MAX_LEN=8).
module tb_signed_sat_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_sat;
  logic [3:0] out_count;

  int checks;
  int failures;

  signed_sat_accumulator #(
    .WIDTH  (4),
    .MAX_LEN(8),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_sat  (out_sat),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted input beat; returns 1 ns after the capturing edge.
  task automatic beat(input logic [3:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'h0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] sum, input logic sat,
                              input logic [3:0] cnt);
    chk({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
    chk({tag, "_sum"},   32'(out_sum),   32'(sum));
    chk({tag, "_sat"},   32'(out_sat),   32'(sat));
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
  endtask

  // Drain one result and confirm the block is collecting again.
  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 32'(1'b0));
    chk({tag, "_drain_ready"}, 32'(in_ready),  32'(1'b1));
  endtask

  task automatic idle_gap();
    int n;
    n = int'($urandom_range(0, 2));
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_ready", 32'(in_ready),  32'(1'b1));
    chk("rst_sum",   32'(out_sum),   32'h0);
    chk("rst_count", 32'(out_count), 32'h0);
    rst_n = 1'b1;

    // Reset mid-frame: partial frame {3,2} is discarded.
    beat(4'h3, 1'b0);
    beat(4'h2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'(1'b0));
    chk("midrst_sum",   32'(out_sum),   32'h0);
    chk("midrst_sat",   32'(out_sat),   32'h0);
    chk("midrst_count", 32'(out_count), 32'h0);
    #1;
    rst_n = 1'b1;
    beat(4'h1, 1'b1);
    check_result("after_rst", 4'h1, 1'b0, 4'd1);
    take("after_rst");

    // Positive clamp: 7 + 7 -> 7.
    beat(4'h7, 1'b0);
    chk("pos_not_yet", 32'(out_valid), 32'(1'b0));
    beat(4'h7, 1'b1);
    check_result("pos_clamp", 4'h7, 1'b1, 4'd2);
    take("pos_clamp");

    // Negative clamp then recovery: -8, -1 -> -8, +5 -> -3.
    beat(4'h8, 1'b0);
    beat(4'hF, 1'b0);
    beat(4'h5, 1'b1);
    check_result("neg_clamp", 4'hD, 1'b1, 4'd3);
    take("neg_clamp");

    // Forced close after MAX_LEN beats of 1 with no in_last.
    for (int i = 0; i < 7; i++) beat(4'h1, 1'b0);
    chk("full_7_valid", 32'(out_valid), 32'(1'b0));
    beat(4'h1, 1'b0);
    check_result("full", 4'h7, 1'b1, 4'd8);
    chk("full_ready", 32'(in_ready), 32'(1'b0));

    // Backpressure: result held while out_ready stays low and input is offered.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'h3;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", 32'(in_ready), 32'(1'b0));
      chk("bp_hold",  32'({out_valid, out_sat, out_count, out_sum}), 32'({1'b1, 1'b1, 4'd8, 4'h7}));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'(1'b0));
    chk("bp_release_ready", 32'(in_ready),  32'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("bp_next", 4'h3, 1'b0, 4'd1);
    take("bp_next");

    // Back-to-back frames with idle gaps; no state carries over.
    beat(4'h2, 1'b0);
    idle_gap();
    beat(4'hD, 1'b1);
    check_result("b2b_a", 4'hF, 1'b0, 4'd2);
    take("b2b_a");
    idle_gap();
    beat(4'hC, 1'b0);
    idle_gap();
    beat(4'hC, 1'b0);
    idle_gap();
    beat(4'hF, 1'b1);
    check_result("b2b_b", 4'h8, 1'b1, 4'd3);
    take("b2b_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
